word_display_scanner: RTL and testbench
=======================================

WORD_DISPLAY_SCANNER -- requirements
Module: word_display_scanner

Interface
REQ-001 Parameter DIV_CNT, default 50000: clock cycles each digit is held active; legal range 2 or more.
REQ-002 Parameter BLINK_FRAMES, default 64: frames per blink period; even, 2 or more; used only when DISPLAY_BLINK_EN is defined.
REQ-003 clk  input  1  sole clock; all state updates on the rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 en  input  1  1 = scan the display, 0 = blank it after the current frame.
REQ-006 word_sel  input  2  word select: 00 FrEE, 01 PArE, 10 ErrO, 11 FULL.
REQ-007 blink  input  1  blink request; present in both builds, ignored without DISPLAY_BLINK_EN.
REQ-008 value  output  4  letter code sent to the segment decoder, registered.
REQ-009 digit_n  output  4  active-low digit enables; bit 3 is the leftmost digit; registered.
REQ-010 frame_done  output  1  one-cycle pulse at the end of each completed frame, registered.

Function
REQ-011 Letter codes SHALL be: F=0, r=1, E=2, P=3, A=4, O=5, U=6, L=7, blank=4'hF.
REQ-012 Words, left to right, SHALL be: FrEE=0,1,2,2; PArE=3,4,1,2; ErrO=2,1,1,5; FULL=0,6,7,7.
REQ-013 The FSM SHALL have two states: IDLE and SCAN.
REQ-014 In IDLE: digit_n=4'b1111, value=4'hF, frame_done=0, dwell counter held at 0.
REQ-015 IDLE to SCAN: on the edge where en=1 is sampled, latch word_sel, set index=0, set digit_n=4'b0111, and drive value with letter 0.
REQ-016 In SCAN the dwell counter SHALL count 0 to DIV_CNT-1; at DIV_CNT-1 it returns to 0 and the index advances.
REQ-017 Output update rules:
- digit_n and value SHALL change on the same edge as the index.
- Index i SHALL drive digit_n[3-i] low, with all other bits high.
- value SHALL be letter i of the latched word.
REQ-018 Frame end: index 3 with counter at DIV_CNT-1.
- frame_done SHALL pulse high on the following cycle.
- If en=1: index wraps to 0 and word_sel is re-latched on that edge.
- If en=0: the FSM returns to IDLE and outputs blank on that edge.
REQ-019 Changes to word_sel mid-frame SHALL NOT affect the current frame; the new word appears from the next frame.
REQ-020 Deasserting en mid-frame SHALL NOT truncate the frame; all 4 digits complete first.
REQ-021 Exactly one bit of digit_n SHALL be low in SCAN at all times; none is low in IDLE.
REQ-022 Each digit SHALL be held active for exactly DIV_CNT cycles; a full frame is 4*DIV_CNT cycles.

Reset
REQ-023 Asserting rst_n=0 SHALL immediately force the following, at any time including mid-frame:
- state IDLE, digit_n=4'b1111, value=4'hF, frame_done=0;
- counter=0, index=0, latched word=00, frame counter=0.
REQ-024 After rst_n is released, the first SCAN entry SHALL follow REQ-015.

Configuration
REQ-025 Macro DISPLAY_BLINK_EN defined: a frame counter SHALL count completed frames modulo BLINK_FRAMES.
- While blink=1 and the frame counter is at least BLINK_FRAMES/2, value SHALL be 4'hF.
- digit_n SHALL continue scanning during blanked frames, and frame_done SHALL still pulse.
- The frame counter SHALL reset to 0 on entry to IDLE.
REQ-026 Macro DISPLAY_BLINK_EN undefined: no frame counter is built, blink is ignored, and value always follows REQ-017.

Verification (DIV_CNT=4, BLINK_FRAMES=4)
REQ-027 Reset, then en=1 with word_sel=00 -> digit_n sequence 0111,1011,1101,1110 with value 0,1,2,2, 4 cycles each, and frame_done pulses once every 16 cycles.
REQ-028 word_sel changed from 01 to 10 at cycle 6 of a frame -> remainder of that frame shows PArE codes; the next frame shows 2,1,1,5.
REQ-029 en dropped at cycle 2 of a frame -> the frame completes, frame_done pulses, then digit_n=1111 and value=F are held.
REQ-030 rst_n pulsed low during digit 2 -> outputs go blank asynchronously, before the next clock edge; after release with en=1, the scan restarts at digit 0.
REQ-031 DISPLAY_BLINK_EN defined, blink=1, word 11 -> frames 0-1 show 0,6,7,7; frames 2-3 show value F while digit_n keeps scanning; the pattern repeats.
REQ-032 DISPLAY_BLINK_EN undefined, blink=1 -> every frame shows 0,6,7,7.

Source files
------------

// File: rtl/word_display_scanner.sv
// rtl/word_display_scanner.sv - four-digit multiplexed word display scanner (optional blink: DISPLAY_BLINK_EN)
module word_display_scanner #(
    parameter int DIV_CNT      = 50000,
    parameter int BLINK_FRAMES = 64
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic [1:0] word_sel,
    input  logic       blink,
    output logic [3:0] value,
    output logic [3:0] digit_n,
    output logic       frame_done
);

    typedef enum logic {IDLE, SCAN} state_t;

    localparam int             CW   = $clog2(DIV_CNT);
    localparam logic [CW-1:0]  LAST = CW'(DIV_CNT - 1);
    localparam logic [3:0]     BLANK = 4'hF;

    state_t        state;
    logic [CW-1:0] cnt;
    logic [1:0]    idx;
    logic [1:0]    word;
    logic [1:0]    idx_nxt;
    logic          blank_cur;
    logic          blank_nxt;

    function automatic logic [3:0] letter(input logic [1:0] w, input logic [1:0] i);
        logic [15:0] codes;
        case (w)
            2'b00:   codes = 16'h0122;
            2'b01:   codes = 16'h3412;
            2'b10:   codes = 16'h2115;
            default: codes = 16'h0677;
        endcase
        case (i)
            2'd0:    letter = codes[15:12];
            2'd1:    letter = codes[11:8];
            2'd2:    letter = codes[7:4];
            default: letter = codes[3:0];
        endcase
    endfunction

    function automatic logic [3:0] digit_sel(input logic [1:0] i);
        digit_sel = ~(4'b1000 >> i);
    endfunction

    assign idx_nxt = idx + 2'd1;

`ifdef DISPLAY_BLINK_EN
    localparam int            FW   = $clog2(BLINK_FRAMES);
    localparam logic [FW-1:0] HALF = FW'(BLINK_FRAMES / 2);

    logic [FW-1:0] frame_cnt;
    logic [FW-1:0] frame_nxt;

    // blank_nxt looks at the count the next frame will carry, for its digit 0
    always_comb begin
        frame_nxt = (frame_cnt == FW'(BLINK_FRAMES - 1)) ? '0 : frame_cnt + 1'b1;
        blank_cur = blink && (frame_cnt >= HALF);
        blank_nxt = blink && (frame_nxt >= HALF);
    end
`else
    localparam int unused_blink_frames = BLINK_FRAMES;
    logic unused_blink;
    assign unused_blink = blink;
    assign blank_cur    = 1'b0;
    assign blank_nxt    = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            cnt        <= '0;
            idx        <= 2'd0;
            word       <= 2'b00;
            value      <= BLANK;
            digit_n    <= 4'b1111;
            frame_done <= 1'b0;
`ifdef DISPLAY_BLINK_EN
            frame_cnt  <= '0;
`endif
        end else begin
            frame_done <= 1'b0;
            case (state)
                IDLE: begin
                    cnt     <= '0;
                    idx     <= 2'd0;
                    value   <= BLANK;
                    digit_n <= 4'b1111;
                    if (en) begin
                        state   <= SCAN;
                        word    <= word_sel;
                        digit_n <= digit_sel(2'd0);
                        value   <= blank_cur ? BLANK : letter(word_sel, 2'd0);
                    end
                end
                SCAN: begin
                    if (cnt != LAST) begin
                        cnt <= cnt + 1'b1;
                    end else begin
                        cnt <= '0;
                        if (idx != 2'd3) begin
                            idx     <= idx_nxt;
                            digit_n <= digit_sel(idx_nxt);
                            value   <= blank_cur ? BLANK : letter(word, idx_nxt);
                        end else begin
                            frame_done <= 1'b1;
                            idx        <= 2'd0;
                            if (en) begin
                                word    <= word_sel;
                                digit_n <= digit_sel(2'd0);
                                value   <= blank_nxt ? BLANK : letter(word_sel, 2'd0);
`ifdef DISPLAY_BLINK_EN
                                frame_cnt <= frame_nxt;
`endif
                            end else begin
                                state   <= IDLE;
                                digit_n <= 4'b1111;
                                value   <= BLANK;
`ifdef DISPLAY_BLINK_EN
                                frame_cnt <= '0;
`endif
                            end
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_word_display_scanner.sv
// tb/tb_word_display_scanner.sv - directed self-checking bench for word_display_scanner
module tb_word_display_scanner;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       en;
    logic [1:0] word_sel;
    logic       blink;
    logic [3:0] value;
    logic [3:0] digit_n;
    logic       frame_done;

    int checks = 0;
    int fails  = 0;

    word_display_scanner #(.DIV_CNT(4), .BLINK_FRAMES(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (en),
        .word_sel   (word_sel),
        .blink      (blink),
        .value      (value),
        .digit_n    (digit_n),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [3:0] got, input logic [3:0] exp);
        checks++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    // One 16-cycle frame sampled on falling edges; k==chg_at applies a mid-frame input change.
    task automatic frame(input string tag, input logic [15:0] letters, input logic blanked,
                         input logic fd0, input int chg_at, input logic [1:0] ws_new,
                         input logic en_new);
        logic [3:0] exp_v;
        for (int k = 0; k < 16; k++) begin
            @(negedge clk);
            exp_v = blanked ? 4'hF : letters[15 - 4 * (k / 4) -: 4];
            check($sformatf("%s_digit_k%0d", tag, k), digit_n, ~(4'b1000 >> (k / 4)));
            check($sformatf("%s_value_k%0d", tag, k), value, exp_v);
            check($sformatf("%s_fdone_k%0d", tag, k), {3'b0, frame_done},
                  {3'b0, (k == 0) ? fd0 : 1'b0});
            if (k == chg_at) begin
                word_sel = ws_new;
                en       = en_new;
            end
        end
    endtask

    task automatic idle_check(input string tag, input logic fd0, input int n);
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            check($sformatf("%s_digit_%0d", tag, k), digit_n, 4'b1111);
            check($sformatf("%s_value_%0d", tag, k), value, 4'hF);
            check($sformatf("%s_fdone_%0d", tag, k), {3'b0, frame_done},
                  {3'b0, (k == 0) ? fd0 : 1'b0});
        end
    endtask

    logic blank_f;

    initial begin
        rst_n = 1'b0; en = 1'b0; word_sel = 2'b00; blink = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_digit", digit_n, 4'b1111);
        check("rst_value", value, 4'hF);
        check("rst_fdone", {3'b0, frame_done}, 4'h0);

        rst_n = 1'b1;
        idle_check("idle_en0", 1'b0, 3);

        // FrEE, then PArE selected late in frame 2, then 01->10 at cycle 6 of the PArE frame
        en = 1'b1; word_sel = 2'b00;
        frame("free1", 16'h0122, 1'b0, 1'b0, -1, 2'b00, 1'b1);
        frame("free2", 16'h0122, 1'b0, 1'b1, 10, 2'b01, 1'b1);
        frame("pare",  16'h3412, 1'b0, 1'b1, 6,  2'b10, 1'b1);
        frame("erro",  16'h2115, 1'b0, 1'b1, 2,  2'b10, 1'b0);
        idle_check("idle_after", 1'b1, 4);

        // blink run on FULL: frames 2-3 of each 4-frame period blank when the feature is built
        blink = 1'b1; word_sel = 2'b11; en = 1'b1;
        for (int f = 0; f < 5; f++) begin
`ifdef DISPLAY_BLINK_EN
            blank_f = ((f % 4) >= 2);
`else
            blank_f = 1'b0;
`endif
            frame($sformatf("full_f%0d", f), 16'h0677, blank_f, (f != 0), (f == 4) ? 0 : -1,
                  2'b11, 1'b0);
        end
        idle_check("idle_blink", 1'b1, 2);
        blink = 1'b0;

        // asynchronous reset during digit 2, then restart at digit 0
        word_sel = 2'b00; en = 1'b1;
        repeat (10) @(negedge clk);
        check("pre_rst_digit", digit_n, 4'b1101);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_digit", digit_n, 4'b1111);
        check("async_rst_value", value, 4'hF);
        check("async_rst_fdone", {3'b0, frame_done}, 4'h0);
        @(negedge clk);
        rst_n = 1'b1;
        frame("restart", 16'h0122, 1'b0, 1'b0, 15, 2'b00, 1'b0);
        idle_check("idle_end", 1'b1, 2);

        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end

endmodule
